aoi_pipe: RTL and testbench
===========================

// Module: aoi_pipe
// PURPOSE
//  Parametrised, pipelined AND-OR-INVERT unit: GROUPS two-input AND terms per bit lane, OR-reduced across groups, optionally inverted.
//  WIDTH independent bit lanes, two register stages, valid/ready handshake on both sides.
//  Exposes the registered AND terms alongside the final result.
//  Sits between operand-producing logic and any consumer that applies backpressure.
// PARAMETERS
//  WIDTH   8  bit lanes per operand
//  GROUPS  2  number of AND terms OR-ed per lane (>=1)
//  CNT_W   16 width of transaction counter (only with AOI_PIPE_STATS_EN)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             input beat valid
//  in_ready   out  1             unit can accept beat this cycle
//  in_a       in   GROUPS*WIDTH  operand A, group g at [g*WIDTH +: WIDTH]
//  in_b       in   GROUPS*WIDTH  operand B, same packing
//  in_mode    in   1             1 = AOI (invert), 0 = AO (no invert); travels with beat
//  out_valid  out  1             result beat valid
//  out_ready  in   1             consumer accepts beat
//  out_terms  out  GROUPS*WIDTH  registered a[g]&b[g], same packing
//  out_y      out  WIDTH         mode ? ~|terms : |terms (OR across groups per lane)
//  stat_cnt   out  CNT_W         output handshakes (only with AOI_PIPE_STATS_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): both stage valids=0, out_valid=0, out_terms=0, out_y=0, stat_cnt=0; in_ready=1 once rst_n=1.
//  Transfer on a side = valid & ready same posedge.
//  S1 captures terms[g]=in_a[g]&in_b[g] and mode; S2 captures terms and y computed from S1.
//  Latency: accepted beat appears on out_* exactly 2 cycles later when out_ready stays 1.
//  Throughput: 1 beat/cycle; stage advances when its successor is empty or draining this cycle.
//  s2_ready = !s2_valid | out_ready; s1_ready = !s1_valid | s2_ready; in_ready = s1_ready (combinational path from out_ready allowed).
//  Stall: while out_valid & !out_ready, out_terms/out_y/out_valid hold stable; capacity 2 beats, then in_ready=0.
//  Full pipe + out_ready=1 + in_valid=1: one beat out, one beat in, same cycle; no bubble.
//  Order strictly preserved; no beat dropped or duplicated.
//  Data registers load only on advance; valid bits cleared when stage drains with no refill.
//  GROUPS=1: out_y = mode ? ~(a&b) : (a&b).
//  Reset mid-operation: all in-flight beats discarded immediately; no partial output.
// CONFIGURATION
//  AOI_PIPE_STATS_EN defined: stat_cnt port present, +1 per output transfer, saturates at all-ones, cleared only by reset.
//  Not defined: stat_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package aoi_pkg: localparam AOI_MODE_AO=1'b0, AOI_MODE_AOI=1'b1; function aoi_reduce(terms, mode).
//  Sub-module aoi_stage: one valid/ready register slice (parametrised data width); instantiated twice.
//  Top does packing, AND terms, OR/invert reduction between slices, optional counter.
// TESTING (WIDTH=8, GROUPS=2, CNT_W=8)
//  Reset: rst_n=0 mid-traffic -> out_valid=0, out_y=0, in_ready=1 after release, stat_cnt=0.
//  a0=F0,b0=CC,a1=0F,b1=33,mode=1,out_ready=1 -> 2 cycles later terms0=C0, terms1=03, out_y=3C.
//  Same operands, mode=0 -> out_y=C3; mode change between back-to-back beats applies per beat.
//  Stream 5 beats, out_ready=0 for 3 cycles -> 2 held, in_ready=0, stable outputs; release -> all 5 in order.
//  Full pipe, in_valid=1, out_ready=1 continuous -> 1 beat/cycle, no bubble, no loss.
//  STATS_EN: 300 output transfers -> stat_cnt=FF and stays FF.

Source files
------------

// File: rtl/aoi_pkg.sv
// Shared constants and the per-lane OR/invert reduction for the AND-OR-INVERT pipeline.
package aoi_pkg;

  localparam logic AOI_MODE_AO    = 1'b0;
  localparam logic AOI_MODE_AOI   = 1'b1;
  localparam int   AOI_MAX_GROUPS = 32;

  // Unused upper bits of terms must be zero so they do not disturb the OR.
  function automatic logic aoi_reduce(input logic [AOI_MAX_GROUPS-1:0] terms,
                                      input logic                      mode);
    logic w_or;
    w_or = |terms;
    case (mode)
      AOI_MODE_AO:  return w_or;
      AOI_MODE_AOI: return ~w_or;
      default:      return w_or;
    endcase
  endfunction

endpackage

// File: rtl/aoi_stage.sv
// One valid/ready register slice: loads only on an accepted beat, drops valid when
// it drains with no refill, so it runs at full rate while buffering one beat.
module aoi_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_load;

  assign in_ready  = ~r_valid | out_ready;
  assign w_load    = in_valid & in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Slice register: refill on load, otherwise empty once the consumer takes the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage pipelined AND-OR-INVERT unit (GROUPS <= 32). Defining AOI_PIPE_STATS_EN adds
// the CNT_W parameter and a saturating output-transfer counter on stat_cnt.
module aoi_pipe
  import aoi_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GROUPS = 2
`ifdef AOI_PIPE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GROUPS*WIDTH-1:0] in_a,
  input  logic [GROUPS*WIDTH-1:0] in_b,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GROUPS*WIDTH-1:0] out_terms,
  output logic [WIDTH-1:0]        out_y
`ifdef AOI_PIPE_STATS_EN
  , output logic [CNT_W-1:0]      stat_cnt
`endif
);

  localparam int TW = GROUPS * WIDTH;

  logic                      w_s1_valid;
  logic                      w_s2_ready;
  logic [TW:0]               w_s1_data;
  logic [TW-1:0]             w_s1_terms;
  logic                      w_s1_mode;
  logic [WIDTH-1:0]          w_s2_in_y;
  logic [WIDTH+TW-1:0]       w_s2_data;
  logic [AOI_MAX_GROUPS-1:0] w_col;

  assign w_s1_mode  = w_s1_data[TW];
  assign w_s1_terms = w_s1_data[TW-1:0];

  aoi_stage #(.DW(TW + 1)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_mode, in_a & in_b}),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_ready),
    .out_data  (w_s1_data)
  );

  // Per-lane column of AND terms across groups, reduced with the beat's own mode.
  always_comb begin
    w_s2_in_y = '0;
    w_col     = '0;
    for (int l = 0; l < WIDTH; l++) begin
      w_col = '0;
      for (int g = 0; g < GROUPS; g++) begin
        w_col[g] = w_s1_terms[g*WIDTH + l];
      end
      w_s2_in_y[l] = aoi_reduce(w_col, w_s1_mode);
    end
  end

  aoi_stage #(.DW(WIDTH + TW)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_ready),
    .in_data   ({w_s2_in_y, w_s1_terms}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_data)
  );

  assign out_terms = w_s2_data[TW-1:0];
  assign out_y     = w_s2_data[WIDTH+TW-1:TW];

`ifdef AOI_PIPE_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  // Output-transfer counter; sticks at all-ones until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign stat_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_aoi_pipe.sv
// Randomised and directed bench for aoi_pipe (WIDTH=8, GROUPS=2) against a queue-based reference.
module tb_aoi_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_terms;
  logic [7:0]  out_y;
`ifdef AOI_PIPE_STATS_EN
  logic [7:0]  stat_cnt;
`endif

  always #5 clk = ~clk;

  aoi_pipe #(
    .WIDTH  (8),
    .GROUPS (2)
`ifdef AOI_PIPE_STATS_EN
    , .CNT_W (8)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_terms (out_terms),
    .out_y     (out_y)
`ifdef AOI_PIPE_STATS_EN
    , .stat_cnt (stat_cnt)
`endif
  );

  typedef struct {
    logic [15:0] terms;
    logic [7:0]  y;
    int          acc;
  } beat_t;

  beat_t       q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_noready = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_y;
  logic [15:0] prev_terms;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_y(input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [7:0] y;
    y = (a[7:0] & b[7:0]) | (a[15:8] & b[15:8]);
    return m ? ~y : y;
  endfunction

  // One clock: drive at negedge, sample 1 ns later, score against the reference queue.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic m, input logic ordy, output logic fired);
    beat_t e;
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; in_mode = m; out_ready = ordy;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_y", {24'd0, out_y}, {24'd0, prev_y});
      check("hold_terms", {16'd0, out_terms}, {16'd0, prev_terms});
    end
    check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || ordy});
    if (out_valid && ordy) begin
      check("q_nonempty", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_terms", {16'd0, out_terms}, {16'd0, e.terms});
        check("out_y", {24'd0, out_y}, {24'd0, e.y});
        if (last_noready <= e.acc) check("latency", cyc - e.acc, 32'd2);
      end
    end
    if (!ordy) last_noready = cyc;
    prev_stall = out_valid && !ordy;
    prev_y = out_y;
    prev_terms = out_terms;
    fired = iv && in_ready;
    if (fired) q.push_back('{terms: a & b, y: ref_y(a, b, m), acc: cyc});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y", {24'd0, out_y}, 32'd0);
    check("rst_out_terms", {16'd0, out_terms}, 32'd0);
`ifdef AOI_PIPE_STATS_EN
    check("rst_stat_cnt", {24'd0, stat_cnt}, 32'd0);
`endif
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    logic f;
    for (int k = 0; k < 10 && q.size() != 0; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, f);
    check("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    logic        f;
    logic [15:0] ra, rb;
    logic        rm;
    int          sent;
    int          k;

    do_reset();

    // Directed vector: AOI then AO on back-to-back beats.
    step(1'b1, 16'h0FF0, 16'h33CC, 1'b1, 1'b1, f);
    step(1'b1, 16'h0FF0, 16'h33CC, 1'b0, 1'b1, f);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, f);
    check("dir_valid_aoi", {31'd0, out_valid}, 32'd1);
    check("dir_terms", {16'd0, out_terms}, 32'h03C0);
    check("dir_y_aoi", {24'd0, out_y}, 32'h3C);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, f);
    check("dir_y_ao", {24'd0, out_y}, 32'hC3);
    drain();

    // Five beats against a consumer that stalls for the first three cycles.
    sent = 0; k = 0;
    ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
    while (sent < 5 && k < 40) begin
      step(1'b1, ra, rb, rm, k >= 3, f);
      if (k == 2) check("stall_full", {31'd0, in_ready}, 32'd0);
      if (f) begin
        sent++;
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      end
      k++;
    end
    check("stall_sent", sent, 32'd5);
    drain();

    // Continuous traffic must move one beat per cycle.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, f);
      check("tput_accept", {31'd0, f}, 32'd1);
      if (i >= 2) check("no_bubble", {31'd0, out_valid}, 32'd1);
    end
    drain();

    // Random valid/ready traffic; input data held until accepted.
    ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, ra, rb, rm, $urandom_range(0, 3) != 0, f);
      if (f) begin
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      end
    end
    drain();

    // Reset with the pipe full must discard everything.
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, f);
    do_reset();
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, f);
    check("post_rst_empty", {31'd0, out_valid}, 32'd0);

`ifdef AOI_PIPE_STATS_EN
    do_reset();
    for (int i = 0; i < 302; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, f);
    check("stat_sat", {24'd0, stat_cnt}, 32'hFF);
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, f);
    check("stat_hold", {24'd0, stat_cnt}, 32'hFF);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
